rr_arbiter3: RTL and testbench
==============================

// Module: rr_arbiter3
// PURPOSE
// - Round-robin arbiter sharing one 3:1 datapath mux (and the shared resource behind it) among three requesters.
// - Drives the mux select (00=a, 01=b, 10=c) plus one-hot grants; tracks multi-beat transfers against a downstream ready.
// - Sits between three bus masters (e.g. fetch, load/store, debug) and one memory/writeback port.
// PARAMETERS
// - HOLD_MAX   16   beats one owner may hold the grant while others wait (used only with ARB_HOLD_LIMIT_EN); >=2
// PORTS
// - clk        in   1  clock, all state on rising edge
// - nreset     in   1  asynchronous active-low reset
// - req        in   3  req[i]: requester i wants or holds the resource
// - last       in   3  last[i]: requester i's current beat is its final beat
// - ready      in   1  downstream accepts the beat this cycle
// - gnt        out  3  one-hot grant, registered; 0 when idle
// - sel        out  2  mux select = index of owner; 2'b00 when idle; never 2'b11
// - busy       out  1  a grant is active (|gnt)
// - beat       out  1  comb: busy & req[owner] & ready (a beat transfers this cycle)
// - preempt    out  1  one-cycle pulse: owner was force-released by hold limit (0 if macro off)
// BEHAVIOUR
// - Reset (nreset=0, async): state=IDLE, gnt=0, sel=00, busy=0, preempt=0, ptr=0, hold_cnt=0.
// - Rotating priority pointer ptr (0..2): search order ptr, ptr+1, ptr+2 (mod 3).
// - IDLE: if |req, winner = first set bit in search order; next cycle gnt/sel=winner, state=GRANT.
//   Latency: req rising in cycle N -> gnt in cycle N+1. No req -> stay IDLE.
// - GRANT (owner=o): gnt/sel held constant; a beat occurs on req[o]&ready.
// - Release events in GRANT (evaluated same cycle):
//   - normal: beat & last[o]
//   - abort: !req[o] (withdrawn; no beat counted)
//   - preempt: hold limit reached (macro only, see CONFIGURATION)
// - On release: ptr <= o+1 mod 3; re-arbitrate the same cycle over req excluding o, using the new ptr.
//   - If a winner exists: next cycle gnt=winner (back-to-back, no idle bubble), state stays GRANT.
//   - Otherwise: next cycle gnt=0, sel=00, state=IDLE.
// - The released owner may not win the same arbitration; it competes again from the next cycle.
// - req[i] rising while another owner holds: waits; grant order is strictly rotating, so each waiter
//   is served within 2 grants.
// - ready low: no beat, grant held indefinitely (unless abort/preempt).
// - last[i] ignored when i is not the owner or when no beat occurs.
// - Reset mid-transfer: grant dropped immediately (async); no completion signalled.
// - Invariants: $onehot0(gnt); sel==index(gnt); busy==|gnt.
// CONFIGURATION
// - Macro ARB_HOLD_LIMIT_EN:
//   - Defined: hold_cnt ($clog2(HOLD_MAX+1) bits) counts beats of the current grant; cleared on every new grant.
//     When a beat makes hold_cnt reach HOLD_MAX, last[o] is 0, and any other req is set: release after that
//     beat (preempt=1 next cycle, aligned with the new gnt). With no other req pending the owner keeps the
//     grant and hold_cnt saturates at HOLD_MAX; a later competing req triggers preempt on the owner's next beat.
//   - Undefined: no counter; grant is released only by last or abort; preempt tied 0.
// TESTING
// - Reset: nreset=0 with req=3'b111 -> gnt=0, sel=00, busy=0; release -> gnt=001 next cycle, sel=00.
// - Rotation: req=111 held, ready=1, last=111 every cycle -> gnt sequence 001,010,100,001..., sel 00,01,10, no gaps.
// - Multi-beat: req=010 only, last[1] on 4th beat with ready toggling 1,0,1,1,1 -> gnt=010 for 5 cycles, then 0, sel=00.
// - Abort: owner 0 drops req mid-transfer while req[2]=1 -> next cycle gnt=100, ptr=1.
// - Hold limit (macro on, HOLD_MAX=4): req=011, owner 0 never asserts last, ready=1 -> after 4 beats gnt=010, preempt=1 one cycle.
// - Macro off, same stimulus -> gnt stays 001, preempt=0 throughout.

Source files
------------

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: one-hot grant plus 3:1 mux select, tracks multi-beat ownership.
// Latency: req in cycle N -> gnt in N+1; a release hands over back-to-back with no idle cycle.
// Backpressure: ready low stalls beats and holds the grant; ARB_HOLD_LIMIT_EN adds hold-limit preemption.
module rr_arbiter3 #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [2:0] req,
    input  logic [2:0] last,
    input  logic       ready,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       beat,
    output logic       preempt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    if (HOLD_MAX < 2) begin : g_bad_hold_max
        $error("rr_arbiter3: HOLD_MAX must be at least 2");
    end

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic [1:0] ptr;
    logic [1:0] ptr_nxt;
    logic [2:0] gnt_nxt;
    logic [1:0] sel_nxt;
    logic       preempt_nxt;

    logic [2:0] own_mask;
    logic       own_req;
    logic       own_last;
    logic       rel_normal;
    logic       rel_abort;
    logic       rel_hold;
    logic       release_evt;

    logic [2:0] cand;
    logic [1:0] arb_ptr;
    logic       found;
    logic [1:0] win;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    assign own_mask = 3'b001 << sel;
    assign own_req  = |(req & own_mask);
    assign own_last = |(last & own_mask);
    assign busy     = |gnt;
    assign beat     = busy & own_req & ready;

    assign rel_normal  = beat & own_last;
    assign rel_abort   = busy & ~own_req;
    assign release_evt = rel_normal | rel_abort | rel_hold;

    // On release the owner is excluded and the search starts just past it.
    assign arb_ptr = release_evt ? inc3(sel) : ptr;
    assign cand    = release_evt ? (req & ~own_mask) : req;

    always_comb begin
        logic [1:0] idx;
        found = 1'b0;
        win   = 2'd0;
        idx   = arb_ptr;
        for (int k = 0; k < 3; k++) begin
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = inc3(idx);
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        sel_nxt     = sel;
        ptr_nxt     = ptr;
        preempt_nxt = 1'b0;
        if (state == ST_IDLE) begin
            if (found) begin
                state_nxt = ST_GRANT;
                gnt_nxt   = 3'b001 << win;
                sel_nxt   = win;
            end
        end else if (release_evt) begin
            ptr_nxt     = inc3(sel);
            preempt_nxt = rel_hold;
            if (found) begin
                gnt_nxt = 3'b001 << win;
                sel_nxt = win;
            end else begin
                state_nxt = ST_IDLE;
                gnt_nxt   = 3'b000;
                sel_nxt   = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= ST_IDLE;
            gnt     <= 3'b000;
            sel     <= 2'd0;
            ptr     <= 2'd0;
            preempt <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            sel     <= sel_nxt;
            ptr     <= ptr_nxt;
            preempt <= preempt_nxt;
        end
    end

`ifdef ARB_HOLD_LIMIT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] hold_cnt;

    // Fires on the beat that reaches the limit, or on any beat once saturated, if someone else waits.
    assign rel_hold = beat & ~own_last & (hold_cnt >= CW'(HOLD_MAX - 1)) & |(req & ~own_mask);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hold_cnt <= '0;
        end else if (state == ST_IDLE || release_evt) begin
            hold_cnt <= '0;
        end else if (beat && hold_cnt != CW'(HOLD_MAX)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign rel_hold = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter3.sv
// Bench for rr_arbiter3: directed scenarios plus random traffic against an ownership-level model.
module tb_rr_arbiter3;
    localparam int HOLD_MAX = 4;
`ifdef ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] last = 3'b000;
    logic       ready = 1'b0;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       beat;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt = 0;
    int m_pre = 0;

    rr_arbiter3 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .nreset(nreset), .req(req), .last(last), .ready(ready),
        .gnt(gnt), .sel(sel), .busy(busy), .beat(beat), .preempt(preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int p, input int excl);
        for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (p + k) % 3;
            if (idx != excl && r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_cnt = 0; m_pre = 0;
    endtask

    task automatic model_step(input logic [2:0] r, input logic [2:0] l, input logic rd);
        int  o;
        bit  b, rel, others;
        m_pre = 0;
        if (m_owner < 0) begin
            m_owner = pick(r, m_ptr, -1);
            m_cnt   = 0;
        end else begin
            o      = m_owner;
            b      = r[o] && rd;
            others = (r & ~(3'b001 << o)) != 3'b000;
            rel    = !r[o] || (b && l[o]);
            if (b && !rel) begin
                if (m_cnt < HOLD_MAX) m_cnt++;
                if (HOLD_EN && m_cnt == HOLD_MAX && others) begin
                    rel   = 1;
                    m_pre = 1;
                end
            end
            if (rel) begin
                m_ptr   = (o + 1) % 3;
                m_owner = pick(r, m_ptr, o);
                m_cnt   = 0;
            end
        end
    endtask

    task automatic check_regs();
        chk("gnt", int'(gnt), (m_owner < 0) ? 0 : (1 << m_owner));
        chk("sel", int'(sel), (m_owner < 0) ? 0 : m_owner);
        chk("busy", int'(busy), (m_owner < 0) ? 0 : 1);
        chk("preempt", int'(preempt), m_pre);
    endtask

    // One clock: drive inputs after the edge, check the comb beat, then the registered outputs.
    task automatic step(input logic [2:0] r, input logic [2:0] l, input logic rd);
        req = r; last = l; ready = rd;
        #1;
        chk("beat", int'(beat), (m_owner >= 0 && r[m_owner] && rd) ? 1 : 0);
        model_step(r, l, rd);
        @(posedge clk); #1;
        check_regs();
    endtask

    initial begin
        int exp_rot [6];
        int hold_cycles;
        exp_rot = '{2, 4, 1, 2, 4, 1};

        nreset = 1'b0; req = 3'b111;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_preempt", int'(preempt), 0);
        nreset = 1'b1;
        step(3'b111, 3'b000, 1'b1);
        chk("rst_first_gnt", int'(gnt), 1);

        for (int i = 0; i < 6; i++) begin
            step(3'b111, 3'b111, 1'b1);
            chk("rot_gnt", int'(gnt), exp_rot[i]);
        end
        step(3'b000, 3'b000, 1'b1);
        chk("drain_gnt", int'(gnt), 0);

        step(3'b010, 3'b000, 1'b1);
        hold_cycles = (gnt == 3'b010) ? 1 : 0;
        step(3'b010, 3'b000, 1'b1);
        if (gnt == 3'b010) hold_cycles++;
        step(3'b010, 3'b000, 1'b0);
        if (gnt == 3'b010) hold_cycles++;
        step(3'b010, 3'b000, 1'b1);
        if (gnt == 3'b010) hold_cycles++;
        step(3'b010, 3'b000, 1'b1);
        if (gnt == 3'b010) hold_cycles++;
        step(3'b010, 3'b010, 1'b1);
        chk("mb_cycles", hold_cycles, 5);
        chk("mb_end_gnt", int'(gnt), 0);
        chk("mb_end_sel", int'(sel), 0);

        step(3'b001, 3'b000, 1'b1);
        step(3'b101, 3'b000, 1'b0);
        chk("abort_pre_gnt", int'(gnt), 1);
        step(3'b100, 3'b000, 1'b1);
        chk("abort_gnt", int'(gnt), 4);
        step(3'b000, 3'b000, 1'b1);
        chk("abort_idle", int'(gnt), 0);

        step(3'b011, 3'b000, 1'b1);
        chk("hold_start", int'(gnt), 1);
        for (int i = 0; i < 3; i++) step(3'b011, 3'b000, 1'b1);
        chk("hold_before", int'(gnt), 1);
        step(3'b011, 3'b000, 1'b1);
        chk("hold_gnt", int'(gnt), HOLD_EN ? 2 : 1);
        chk("hold_preempt", int'(preempt), HOLD_EN ? 1 : 0);
        step(3'b011, 3'b000, 1'b0);
        chk("hold_pulse_end", int'(preempt), 0);

        step(3'b111, 3'b000, 1'b0);
        nreset = 1'b0;
        #1;
        chk("async_rst_gnt", int'(gnt), 0);
        chk("async_rst_busy", int'(busy), 0);
        model_reset();
        @(posedge clk); #1;
        nreset = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] r, l;
            logic       rd;
            r  = 3'($urandom);
            l  = 3'($urandom) & 3'($urandom);
            rd = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) r = 3'b000;
            step(r, l, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
